// File: rtl/reg_cmd_ctrl_pkg.sv
// Shared types for the UART-to-register-file command controller.
// State encoding and frame command bytes.
package reg_cmd_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_SEND
  } state_t;

  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;

endpackage

// File: rtl/reg_cmd_ctrl.sv
// Decodes UART byte frames into register-file strobes
// and returns read data to the UART TX path.
module reg_cmd_ctrl
  import reg_cmd_ctrl_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int ADDR     = 4,
  parameter int FRAME_TO = 255,
  parameter int RD_TO    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] RX_P_DATA,
  input  logic             RX_D_VLD,
  output logic             WrEn,
  output logic             RdEn,
  output logic [ADDR-1:0]  Address,
  output logic [WIDTH-1:0] WrData,
  input  logic [WIDTH-1:0] RdData,
  input  logic             RdData_VLD,
  output logic [WIDTH-1:0] TX_P_DATA,
  output logic             TX_D_VLD,
  input  logic             TX_Busy,
  output logic             CMD_ERR
);

  localparam int CNT_MAX =
    (FRAME_TO > RD_TO) ? FRAME_TO : RD_TO;
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef logic [CW-1:0] cnt_t;

  state_t state, state_nxt;
  cnt_t   cnt, cnt_nxt;

  logic             wr_en_nxt;
  logic             rd_en_nxt;
  logic             err_nxt;
  logic             tx_vld_nxt;
  logic [ADDR-1:0]  addr_nxt;
  logic [WIDTH-1:0] wdata_nxt;
  logic [WIDTH-1:0] txd_nxt;

  logic is_wr, is_rd, addr_ok;
  logic frame_to, rd_to, tx_ack;
  cnt_t cnt_inc;

  assign is_wr    = RX_P_DATA == WIDTH'(CMD_WR);
  assign is_rd    = RX_P_DATA == WIDTH'(CMD_RD);
  assign addr_ok  = (RX_P_DATA >> ADDR) == '0;
  assign frame_to = cnt >= cnt_t'(FRAME_TO - 1);
  assign rd_to    = cnt >= cnt_t'(RD_TO);
  assign tx_ack   = TX_D_VLD && !TX_Busy;
  assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter restarts on every state change and on each frame byte.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    unique case (state)
      IDLE: begin
        if (RX_D_VLD && is_wr) state_nxt = WR_ADDR;
        if (RX_D_VLD && is_rd) state_nxt = RD_ADDR;
      end
      WR_ADDR: begin
        if (RX_D_VLD)
          state_nxt = addr_ok ? WR_DATA : IDLE;
        else if (frame_to) state_nxt = IDLE;
        else cnt_nxt = cnt_inc;
      end
      WR_DATA: begin
        if (RX_D_VLD) state_nxt = IDLE;
        else if (frame_to) state_nxt = IDLE;
        else cnt_nxt = cnt_inc;
      end
      RD_ADDR: begin
        if (RX_D_VLD)
          state_nxt = addr_ok ? RD_WAIT : IDLE;
        else if (frame_to) state_nxt = IDLE;
        else cnt_nxt = cnt_inc;
      end
      RD_WAIT: begin
        if (RdData_VLD) state_nxt = TX_SEND;
        else if (rd_to) state_nxt = IDLE;
        else cnt_nxt = cnt_inc;
      end
      TX_SEND: begin
        if (tx_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_en_nxt  = 1'b0;
    rd_en_nxt  = 1'b0;
    err_nxt    = 1'b0;
    tx_vld_nxt = 1'b0;
    addr_nxt   = Address;
    wdata_nxt  = WrData;
    txd_nxt    = TX_P_DATA;
    unique case (state)
      IDLE: begin
        err_nxt = RX_D_VLD && !is_wr && !is_rd;
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_ok) addr_nxt = RX_P_DATA[ADDR-1:0];
          else err_nxt = 1'b1;
        end else begin
          err_nxt = frame_to;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wdata_nxt = RX_P_DATA;
          wr_en_nxt = 1'b1;
        end else begin
          err_nxt = frame_to;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_ok) begin
            addr_nxt  = RX_P_DATA[ADDR-1:0];
            rd_en_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end else begin
          err_nxt = frame_to;
        end
      end
      RD_WAIT: begin
        err_nxt = RX_D_VLD;
        if (RdData_VLD) begin
          txd_nxt    = RdData;
          tx_vld_nxt = 1'b1;
        end else if (rd_to) begin
          err_nxt = 1'b1;
        end
      end
      TX_SEND: begin
        err_nxt    = RX_D_VLD;
        tx_vld_nxt = !tx_ack;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      CMD_ERR   <= 1'b0;
      TX_D_VLD  <= 1'b0;
      Address   <= '0;
      WrData    <= '0;
      TX_P_DATA <= '0;
    end else begin
      WrEn      <= wr_en_nxt;
      RdEn      <= rd_en_nxt;
      CMD_ERR   <= err_nxt;
      TX_D_VLD  <= tx_vld_nxt;
      Address   <= addr_nxt;
      WrData    <= wdata_nxt;
      TX_P_DATA <= txd_nxt;
    end
  end

endmodule
